vga_pixel_fetch: RTL

- Pixel stage directly downstream of the VGA timing generator.
- Consumes raw x/y counters, hsync, vsync and blank_b from the timing generator each vgaclk cycle.
- Fetches an 8-bit grayscale image, IMG_W x IMG_H, from a synchronous framebuffer RAM and places it in a fixed window. Drives VGA R/G/B with sync signals re-aligned to the pipeline.
- Provides double-buffer bank selection; bank swaps take effect only at the start of vertical blanking.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_fetch_if.sv | 24 ++
 rtl/vga_delay_line.sv | 30 +++
 rtl/vga_pixel_fetch.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and pixel types for the pixel pipeline.
// 640x480@60 timing is shared with the upstream timing generator.
package vga_pkg;

    localparam int HACTIVE = 640;
    localparam int HFP     = 16;
    localparam int HSYN    = 96;
    localparam int HBP     = 48;
    localparam int VACTIVE = 480;
    localparam int VFP     = 10;
    localparam int VSYN    = 2;
    localparam int VBP     = 33;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [23:0] BORDER_DEFAULT = 24'h000040;

    function automatic rgb_t gray(input logic [7:0] v);
        rgb_t c;
        c.r = v;
        c.g = v;
        c.b = v;
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port: registered address/enable/bank out, RAM data back
// one cycle later.
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_bank;
    logic [7:0]        mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        output mem_bank,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        input  mem_bank,
        output mem_data
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that keeps sync/blank/window flags aligned with
// the framebuffer read latency.
module vga_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             vgaclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel stage after the timing generator: windowed framebuffer fetch, colour
// select and double-buffer bank swap applied at the start of vertical blank.
module vga_pixel_fetch #(
    parameter int          HACTIVE = 640,
    parameter int          VACTIVE = 480,
    parameter int          IMG_W   = 256,
    parameter int          IMG_H   = 256,
    parameter int          X0      = 192,
    parameter int          Y0      = 112,
    parameter int          ADDR_W  = 16,
    parameter logic [23:0] BORDER  = vga_pkg::BORDER_DEFAULT
) (
    input  logic                      vgaclk,
    input  logic                      reset,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_b_in,
    input  logic                      swap_req,
    vga_pixel_fetch_if.master         fb,
    output logic [7:0]                vga_r,
    output logic [7:0]                vga_g,
    output logic [7:0]                vga_b,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      blank_b,
    output logic                      swap_ack,
    output logic                      frame_start
);

    import vga_pkg::*;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [10:0] X_BEG = 11'(X0);
    localparam logic [10:0] X_END = 11'(X0 + IMG_W);
    localparam logic [10:0] Y_BEG = 11'(Y0);
    localparam logic [10:0] Y_END = 11'(Y0 + IMG_H);
    localparam logic [10:0] X_VIS = 11'(HACTIVE);

    logic       in_win;
    logic       boundary;
    logic       pending;
    logic [3:0] dly_in;
    logic [3:0] dly_out;
    logic       hs_d;
    logic       vs_d;
    logic       bl_d;
    logic       win_d;
    rgb_t       rgb_q;

    // 11-bit compares so X0+IMG_W cannot wrap; the window never exceeds
    // the visible line, so the HACTIVE guard is only a safety net.
    assign in_win = ({1'b0, x} >= X_BEG) && ({1'b0, x} < X_END) &&
                    ({1'b0, x} < X_VIS) &&
                    ({1'b0, y} >= Y_BEG) && ({1'b0, y} < Y_END) &&
                    blank_b_in;

    assign boundary = (x == 10'd0) && (y == 10'(VACTIVE));

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            fb.mem_rd   <= 1'b0;
            fb.mem_addr <= '0;
        end else begin
            fb.mem_rd <= in_win;
            if (in_win) begin
                fb.mem_addr <= ADDR_W'({YW'(y - 10'(Y0)), XW'(x - 10'(X0))});
            end
        end
    end

    assign dly_in = {hsync_in, vsync_in, blank_b_in, in_win};

    vga_delay_line #(
        .WIDTH (4),
        .DEPTH (2)
    ) u_dly (
        .vgaclk (vgaclk),
        .reset  (reset),
        .din    (dly_in),
        .dout   (dly_out)
    );

    assign {hs_d, vs_d, bl_d, win_d} = dly_out;

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            blank_b <= 1'b0;
        end else begin
            hsync   <= hs_d;
            vsync   <= vs_d;
            blank_b <= bl_d;
            if (!bl_d) begin
                rgb_q <= '0;
            end else if (win_d) begin
                rgb_q <= gray(fb.mem_data);
            end else begin
                rgb_q <= BORDER;
            end
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

    // A request landing on the boundary cycle itself is honoured in that frame.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            pending     <= 1'b0;
            fb.mem_bank <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            swap_ack    <= 1'b0;
            if (boundary) begin
                if (pending || swap_req) begin
                    fb.mem_bank <= ~fb.mem_bank;
                    pending     <= 1'b0;
                    swap_ack    <= 1'b1;
                end
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
